// File: rtl/offset_agu.sv
// offset_agu -- pipelined address-generation unit.
// Adds a sign-extended immediate offset to a base address and returns the
// access address plus a base-register writeback value. Supports OFFSET, PRE,
// POST and strided BURST modes behind valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid && in_ready
//   base       base address
//   offset     two's-complement offset / burst stride
//   mode       00 OFFSET, 01 PRE, 10 POST, 11 BURST
//   burst_len  beats-1 (BURST only)
//   out_valid  beat valid
//   out_ready  beat consumed when out_valid && out_ready
//   addr       access address
//   wb_addr    base-register writeback value
//   last       final beat of the request
//   busy       burst in progress
module offset_agu #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OFFSET_WIDTH = 12,
  parameter int unsigned BURST_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   base,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [1:0]              mode,
  input  logic [BURST_WIDTH-1:0]  burst_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wb_addr,
  output logic                    last,
  output logic                    busy
);

  typedef enum logic [1:0] {
    MODE_OFFSET = 2'b00,
    MODE_PRE    = 2'b01,
    MODE_POST   = 2'b10,
    MODE_BURST  = 2'b11
  } mode_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wb_addr;
  logic                    r_last;
  logic [BURST_WIDTH-1:0]  r_cnt;
  logic [BURST_WIDTH-1:0]  r_len;
  logic [DATA_WIDTH-1:0]   r_soff;

  mode_e                   w_mode;
  logic [DATA_WIDTH-1:0]   w_soff;
  logic [DATA_WIDTH-1:0]   w_sum;
  logic [DATA_WIDTH-1:0]   w_burst_wb;
  logic                    w_free;
  logic                    w_fire_in;
  logic                    w_fire_out;
  logic                    w_start_burst;

  assign w_mode     = mode_e'(mode);
  assign w_soff     = {{(DATA_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
  assign w_sum      = base + w_soff;
  assign w_burst_wb = base + (DATA_WIDTH'(burst_len) + DATA_WIDTH'(1)) * w_soff;

  assign w_fire_out = r_out_valid && out_ready;

  // The final burst beat being consumed frees the unit in the same cycle, so a
  // new request can be taken on that edge without an idle bubble.
  assign w_free    = (r_state == S_IDLE) || (r_last && w_fire_out);
  assign in_ready  = rst_n && w_free && (!r_out_valid || out_ready);
  assign w_fire_in = in_valid && in_ready;
  assign w_start_burst = w_fire_in && (w_mode == MODE_BURST) && (burst_len != '0);

  assign out_valid = r_out_valid;
  assign addr      = r_addr;
  assign wb_addr   = r_wb_addr;
  assign last      = r_last;
  assign busy      = (r_state == S_BURST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_BURST && w_fire_out && r_last) w_state_nxt = S_IDLE;
    if (w_fire_in) w_state_nxt = w_start_burst ? S_BURST : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_addr      <= '0;
      r_wb_addr   <= '0;
      r_last      <= 1'b0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_soff      <= '0;
    end else if (w_fire_in) begin
      r_out_valid <= 1'b1;
      r_cnt       <= '0;
      r_len       <= burst_len;
      r_soff      <= w_soff;
      case (w_mode)
        MODE_OFFSET: begin
          r_addr    <= w_sum;
          r_wb_addr <= base;
          r_last    <= 1'b1;
        end
        MODE_PRE: begin
          r_addr    <= w_sum;
          r_wb_addr <= w_sum;
          r_last    <= 1'b1;
        end
        MODE_POST: begin
          r_addr    <= base;
          r_wb_addr <= w_sum;
          r_last    <= 1'b1;
        end
        default: begin
          r_addr    <= base;
          r_wb_addr <= w_burst_wb;
          r_last    <= (burst_len == '0);
        end
      endcase
    end else if (w_fire_out) begin
      if (r_state == S_BURST && !r_last) begin
        // Step to beat k+1; the beat count never exceeds r_len so no wrap.
        r_addr <= r_addr + r_soff;
        r_cnt  <= r_cnt + BURST_WIDTH'(1);
        r_last <= ((r_cnt + BURST_WIDTH'(1)) == r_len);
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
